// File: rtl/mandel_dispatcher.sv
// Purpose: walks a frame in raster order, hands each pixel (x, y, Re, Im) to an idle engine and turns returned counts into frame-buffer writes.
// Latency: start to first latch_en is 2 cycles; at most one dispatch per 2 cycles; a service costs 1 + ACK_HOLD + 1 + release-wait cycles.
// Backpressure: waits in RUN while every engine is busy; RELEASE waits indefinitely for the serviced engine to drop service_req.
module mandel_dispatcher #(
  parameter int NUM_ENGINES = 8,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int ACK_HOLD    = 3
) (
  input  logic                   Engine_CLK,
  input  logic                   eRST,
  input  logic                   start,
  input  logic [31:0]            re_start,
  input  logic [31:0]            im_start,
  input  logic [31:0]            re_step,
  input  logic [31:0]            im_step,
  output logic [2:0]             engine_addr,
  output logic [82:0]            word,
  output logic                   latch_en,
  input  logic [NUM_ENGINES-1:0] service_req,
  output logic [NUM_ENGINES-1:0] ack,
  input  logic [15:0]            count_output,
  output logic                   fb_we,
  output logic [9:0]             fb_x,
  output logic [8:0]             fb_y,
  output logic [15:0]            fb_data,
  output logic                   busy,
  output logic                   frame_done
);

  typedef enum logic [2:0] {IDLE, RUN, DISPATCH, ACK, CAPTURE, RELEASE, DONE} state_t;

  state_t      state, next_state;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [31:0] re, im, re_base, re_inc, im_inc;
  // Engine bookkeeping is kept 8 wide so a 3-bit engine index always addresses it directly.
  logic [7:0]  eng_busy;
  logic [18:0] tag [8];
  logic [2:0]  cur, sel, last_srv, last_disp;
  logic [7:0]  ack_cnt;
  logic        all_sent;
  logic [7:0]  eng_mask, req_all, svc_cand, free_cand, sel_onehot;

  assign eng_mask   = 8'((9'd1 << NUM_ENGINES) - 9'd1);
  assign req_all    = 8'(service_req);
  // A request only counts from an engine that actually holds a pixel.
  assign svc_cand   = req_all & eng_busy;
  assign free_cand  = ~eng_busy & eng_mask;
  assign sel_onehot = 8'd1 << sel;

  // First candidate found when scanning upward from the index after 'last', wrapping.
  function automatic logic [2:0] rr_pick(input logic [7:0] cand, input logic [2:0] last);
    logic [2:0] pick;
    logic [2:0] idx;
    pick = last;
    for (int k = NUM_ENGINES; k >= 1; k--) begin
      idx = 3'((int'(last) + k) % NUM_ENGINES);
      if (cand[idx]) pick = idx;
    end
    return pick;
  endfunction

  // State register.
  always_ff @(posedge Engine_CLK) begin
    if (eRST) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state decision and engine selection; servicing results beats dispatching.
  always_comb begin
    next_state = state;
    sel        = cur;
    case (state)
      IDLE:     if (start) next_state = RUN;
      RUN: begin
        if (|svc_cand) begin
          next_state = ACK;
          sel        = rr_pick(svc_cand, last_srv);
        end else if (!all_sent && (|free_cand)) begin
          next_state = DISPATCH;
          sel        = rr_pick(free_cand, last_disp);
        end else if (all_sent && (eng_busy == 8'd0)) begin
          next_state = DONE;
        end
      end
      DISPATCH: next_state = RUN;
      ACK:      if (ack_cnt == 8'(ACK_HOLD - 1)) next_state = CAPTURE;
      CAPTURE:  next_state = RELEASE;
      RELEASE:  if (!req_all[cur]) next_state = RUN;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Datapath: registered bus outputs, pixel walker and per-engine busy/tag state.
  always_ff @(posedge Engine_CLK) begin
    if (eRST) begin
      x           <= '0;
      y           <= '0;
      re          <= '0;
      im          <= '0;
      re_base     <= '0;
      re_inc      <= '0;
      im_inc      <= '0;
      eng_busy    <= '0;
      for (int i = 0; i < 8; i++) tag[i] <= '0;
      cur         <= '0;
      last_srv    <= 3'(NUM_ENGINES - 1);
      last_disp   <= 3'(NUM_ENGINES - 1);
      ack_cnt     <= '0;
      all_sent    <= 1'b0;
      engine_addr <= '0;
      word        <= '0;
      latch_en    <= 1'b0;
      ack         <= '0;
      fb_we       <= 1'b0;
      fb_x        <= '0;
      fb_y        <= '0;
      fb_data     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      latch_en   <= 1'b0;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            re_base  <= re_start;
            re_inc   <= re_step;
            im_inc   <= im_step;
            re       <= re_start;
            im       <= im_start;
            x        <= '0;
            y        <= '0;
            eng_busy <= '0;
            all_sent <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          cur <= sel;
          if (next_state == DISPATCH) begin
            latch_en    <= 1'b1;
            engine_addr <= sel;
            word        <= {x, y, re, im};
            last_disp   <= sel;
          end else if (next_state == ACK) begin
            ack      <= sel_onehot[NUM_ENGINES-1:0];
            ack_cnt  <= '0;
            last_srv <= sel;
          end else if (next_state == DONE) begin
            frame_done <= 1'b1;
          end
        end
        DISPATCH: begin
          eng_busy[cur] <= 1'b1;
          tag[cur]      <= {x, y};
          if (x == 10'(H_RES - 1)) begin
            x  <= '0;
            re <= re_base;
            y  <= y + 9'd1;
            im <= im + im_inc;
            if (y == 9'(V_RES - 1)) all_sent <= 1'b1;
          end else begin
            x  <= x + 10'd1;
            re <= re + re_inc;
          end
        end
        ACK: begin
          ack_cnt <= ack_cnt + 8'd1;
          if (next_state == CAPTURE) begin
            ack     <= '0;
            fb_we   <= 1'b1;
            fb_x    <= tag[cur][18:9];
            fb_y    <= tag[cur][8:0];
            fb_data <= count_output;
          end
        end
        RELEASE: if (next_state == RUN) eng_busy[cur] <= 1'b0;
        DONE:    busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_dispatcher.sv
`timescale 1ns/1ps
module tb_mandel_dispatcher;
  localparam int NE = 2;
  localparam int HR = 4;
  localparam int VR = 2;
  localparam int AH = 3;
  localparam int LOGN = 256;

  logic          Engine_CLK = 1'b0;
  logic          eRST = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   re_start = '0, im_start = '0, re_step = '0, im_step = '0;
  logic [2:0]    engine_addr;
  logic [82:0]   word;
  logic          latch_en;
  logic [NE-1:0] service_req;
  logic [NE-1:0] ack;
  logic [15:0]   count_output;
  logic          fb_we;
  logic [9:0]    fb_x;
  logic [8:0]    fb_y;
  logic [15:0]   fb_data;
  logic          busy, frame_done;

  mandel_dispatcher #(.NUM_ENGINES(NE), .H_RES(HR), .V_RES(VR), .ACK_HOLD(AH)) dut (
    .Engine_CLK(Engine_CLK), .eRST(eRST), .start(start),
    .re_start(re_start), .im_start(im_start), .re_step(re_step), .im_step(im_step),
    .engine_addr(engine_addr), .word(word), .latch_en(latch_en),
    .service_req(service_req), .ack(ack), .count_output(count_output),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_data(fb_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 Engine_CLK = ~Engine_CLK;

  int nvec = 0;
  int nerr = 0;

  // Engine model controls.
  int resp_delay [NE];
  int rel_hold = 0;
  // Engine model state.
  logic [NE-1:0] m_active, m_acked, m_rel;
  int            m_dcnt [NE];
  int            m_hcnt [NE];
  int            m_age  [NE];
  logic [18:0]   m_tag  [NE];
  // Bus logs.
  int cyc = 0;
  int disp_n = 0, wr_n = 0, ack_n = 0, fd_n = 0, viol_n = 0, early_n = 0;
  logic [82:0]   disp_word [LOGN];
  logic [2:0]    disp_addr [LOGN];
  int            disp_cyc  [LOGN];
  int            disp_gap  [LOGN];
  logic [9:0]    wr_x      [LOGN];
  logic [8:0]    wr_y      [LOGN];
  logic [15:0]   wr_d      [LOGN];
  logic [18:0]   wr_exp    [LOGN];
  int            wr_cyc    [LOGN];
  logic [NE-1:0] ack_eng   [LOGN];
  int            ack_len   [LOGN];
  logic [NE-1:0] prev_ack = '0;
  int            run_len = 0;
  int            last_acked = 0;
  int            wr_time [NE];

  // Behavioural engines plus bus monitor, evaluated mid-cycle.
  always @(negedge Engine_CLK) begin
    cyc++;
    if (eRST) begin
      m_active = '0; m_acked = '0; m_rel = '0; service_req = '0; count_output = '0;
      prev_ack = '0; run_len = 0;
      for (int i = 0; i < NE; i++) begin wr_time[i] = -1000; m_age[i] = 0; end
    end else begin
      if (latch_en) begin
        if (disp_n < LOGN) begin
          disp_word[disp_n] = word; disp_addr[disp_n] = engine_addr; disp_cyc[disp_n] = cyc;
          disp_gap[disp_n] = 1000;
          for (int i = 0; i < NE; i++)
            if (engine_addr == 3'(i)) begin
              if (m_active[i]) early_n++;
              disp_gap[disp_n] = cyc - wr_time[i];
            end
        end
        disp_n++;
      end
      if (ack != '0) begin
        if (((ack & (ack - 1'b1)) != '0) || latch_en) viol_n++;
        if (ack == prev_ack) run_len++;
        else begin
          if (prev_ack != '0) begin
            if (ack_n < LOGN) begin ack_eng[ack_n] = prev_ack; ack_len[ack_n] = run_len; end
            ack_n++;
          end
          run_len = 1;
        end
        for (int i = 0; i < NE; i++) if (ack[i]) last_acked = i;
      end else if (prev_ack != '0) begin
        if (ack_n < LOGN) begin ack_eng[ack_n] = prev_ack; ack_len[ack_n] = run_len; end
        ack_n++;
      end
      prev_ack = ack;
      if (fb_we) begin
        if (wr_n < LOGN) begin
          wr_x[wr_n] = fb_x; wr_y[wr_n] = fb_y; wr_d[wr_n] = fb_data; wr_cyc[wr_n] = cyc;
          wr_exp[wr_n] = '1;
          for (int i = 0; i < NE; i++) if (last_acked == i) wr_exp[wr_n] = m_tag[i];
        end
        for (int i = 0; i < NE; i++) if (last_acked == i) wr_time[i] = cyc;
        wr_n++;
      end
      if (frame_done) fd_n++;
      for (int i = 0; i < NE; i++) begin
        if (latch_en && engine_addr == 3'(i)) begin
          m_active[i] = 1'b1; m_dcnt[i] = resp_delay[i]; m_tag[i] = word[82:64];
        end else if (m_active[i] && !service_req[i] && !m_rel[i]) begin
          if (m_dcnt[i] == 0) service_req[i] = 1'b1; else m_dcnt[i]--;
        end
        if (ack[i]) begin m_acked[i] = 1'b1; m_age[i]++; end
        else if (m_acked[i]) begin m_acked[i] = 1'b0; m_age[i] = 0; m_rel[i] = 1'b1; m_hcnt[i] = rel_hold; end
        if (m_rel[i]) begin
          if (m_hcnt[i] == 0) begin service_req[i] = 1'b0; m_rel[i] = 1'b0; m_active[i] = 1'b0; end
          else m_hcnt[i]--;
        end
      end
      // The engine needs a cycle of ack before it puts its count on the bus.
      count_output = 16'd0;
      for (int i = 0; i < NE; i++) if (ack[i] && m_age[i] >= 2) count_output = 16'd3;
    end
  end

  task automatic tick();
    @(negedge Engine_CLK);
    #1;
  endtask

  task automatic do_reset();
    tick(); eRST = 1'b1; start = 1'b0;
    repeat (3) tick();
    eRST = 1'b0;
  endtask

  task automatic start_frame(input logic [31:0] rs, input logic [31:0] is, input logic [31:0] rst, input logic [31:0] ist);
    tick(); re_start = rs; im_start = is; re_step = rst; im_step = ist; start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic wait_fd(input int base, input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      if (fd_n > base) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_disp(input int target, input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      if (disp_n >= target) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  function automatic logic [82:0] exp_word(input int px, input int py, input logic [31:0] rs,
                                           input logic [31:0] is, input logic [31:0] rst, input logic [31:0] ist);
    logic [31:0] r, m;
    r = rs + 32'(px) * rst;
    m = is + 32'(py) * ist;
    return {10'(px), 9'(py), r, m};
  endfunction

  localparam logic [31:0] RS = 32'hFE000000, IS = 32'h01000000, RST = 32'h00800000, IST = 32'hFF800000;

  task automatic test_reset();
    tick(); eRST = 1'b1;
    tick(); tick();
    nvec++; if (latch_en !== 1'b0) begin nerr++; $display("FAIL rst_latch_en: got %b want 0", latch_en); end
    nvec++; if (ack !== '0) begin nerr++; $display("FAIL rst_ack: got %b want 0", ack); end
    nvec++; if (fb_we !== 1'b0) begin nerr++; $display("FAIL rst_fb_we: got %b want 0", fb_we); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
    nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    nvec++; if (engine_addr !== 3'd0) begin nerr++; $display("FAIL rst_engine_addr: got %0d want 0", engine_addr); end
    nvec++; if (word !== 83'd0) begin nerr++; $display("FAIL rst_word: got %h want 0", word); end
    nvec++; if ({fb_x, fb_y, fb_data} !== 35'd0) begin nerr++; $display("FAIL rst_fb_bus: got %h want 0", {fb_x, fb_y, fb_data}); end
    eRST = 1'b0;
  endtask

  task automatic test_frame();
    int d0, w0, f0, v0, a0, dup, idx;
    bit ok;
    logic [7:0] seen, b;
    resp_delay[0] = 1; resp_delay[1] = 1; rel_hold = 0;
    do_reset();
    d0 = disp_n; w0 = wr_n; f0 = fd_n; v0 = viol_n; a0 = ack_n;
    start_frame(RS, IS, RST, IST);
    nvec++; if (latch_en !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL f1_start_cycle1: latch_en=%b busy=%b want 0/1", latch_en, busy); end
    tick();
    nvec++; if (latch_en !== 1'b1) begin nerr++; $display("FAIL f1_first_latch: got %b want 1", latch_en); end
    nvec++; if (word !== exp_word(0, 0, RS, IS, RST, IST) || engine_addr !== 3'd0) begin nerr++; $display("FAIL f1_first_word: got %h addr %0d want %h addr 0", word, engine_addr, exp_word(0, 0, RS, IS, RST, IST)); end
    wait_fd(f0, 1000, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL f1_timeout: no frame_done within bound"); end
    tick();
    nvec++; if (busy !== 1'b0 || frame_done !== 1'b0) begin nerr++; $display("FAIL f1_after_done: busy=%b frame_done=%b want 0/0", busy, frame_done); end
    nvec++; if (disp_n - d0 != 8) begin nerr++; $display("FAIL f1_dispatches: got %0d want 8", disp_n - d0); end
    for (int k = 0; k < 8; k++) begin
      nvec++;
      if (disp_word[d0 + k] !== exp_word(k % HR, k / HR, RS, IS, RST, IST)) begin nerr++; $display("FAIL f1_word%0d: got %h want %h", k, disp_word[d0 + k], exp_word(k % HR, k / HR, RS, IS, RST, IST)); end
    end
    nvec++; if (disp_word[d0 + 3][63:32] !== 32'hFF800000) begin nerr++; $display("FAIL f1_re_x3: got %h want ff800000", disp_word[d0 + 3][63:32]); end
    nvec++; if (disp_word[d0 + 4][31:0] !== 32'h00800000) begin nerr++; $display("FAIL f1_im_y1: got %h want 00800000", disp_word[d0 + 4][31:0]); end
    nvec++; if (wr_n - w0 != 8) begin nerr++; $display("FAIL f1_writes: got %0d want 8", wr_n - w0); end
    seen = '0; dup = 0;
    for (int k = w0; k < wr_n && k < w0 + 8; k++) begin
      nvec++; if (wr_d[k] !== 16'd3) begin nerr++; $display("FAIL f1_fb_data%0d: got %0d want 3", k - w0, wr_d[k]); end
      idx = int'(wr_y[k]) * HR + int'(wr_x[k]);
      b = 8'd1 << idx;
      if ((seen & b) != '0) dup++;
      seen |= b;
    end
    nvec++; if (seen !== 8'hFF || dup != 0) begin nerr++; $display("FAIL f1_coverage: got map %h dups %0d want ff 0", seen, dup); end
    nvec++; if (fd_n - f0 != 1) begin nerr++; $display("FAIL f1_frame_done: got %0d pulses want 1", fd_n - f0); end
    nvec++; if (viol_n != v0) begin nerr++; $display("FAIL f1_ack_exclusive: got %0d violations want 0", viol_n - v0); end
    for (int k = a0; k < ack_n && k < a0 + 8; k++) begin
      nvec++; if (ack_len[k] != AH) begin nerr++; $display("FAIL f1_ack_len%0d: got %0d want %0d", k - a0, ack_len[k], AH); end
    end
  endtask

  task automatic test_simultaneous();
    int d0, w0, a0, f0, v0, bad;
    bit ok;
    resp_delay[0] = 4; resp_delay[1] = 2; rel_hold = 0;
    do_reset();
    d0 = disp_n; w0 = wr_n; a0 = ack_n; f0 = fd_n; v0 = viol_n;
    start_frame(RS, IS, RST, IST);
    wait_fd(f0, 1000, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL f2_timeout: no frame_done within bound"); end
    nvec++; if (disp_addr[d0] !== 3'd0 || disp_addr[d0 + 1] !== 3'd1) begin nerr++; $display("FAIL f2_disp_rr: got %0d,%0d want 0,1", disp_addr[d0], disp_addr[d0 + 1]); end
    nvec++; if (ack_eng[a0] !== 2'b01 || ack_eng[a0 + 1] !== 2'b10) begin nerr++; $display("FAIL f2_ack_order: got %b,%b want 01,10", ack_eng[a0], ack_eng[a0 + 1]); end
    nvec++; if (ack_len[a0] != AH || ack_len[a0 + 1] != AH) begin nerr++; $display("FAIL f2_ack_len: got %0d,%0d want %0d", ack_len[a0], ack_len[a0 + 1], AH); end
    nvec++; if ({wr_x[w0], wr_y[w0]} !== 19'd0) begin nerr++; $display("FAIL f2_wr0_tag: got x%0d y%0d want x0 y0", wr_x[w0], wr_y[w0]); end
    nvec++; if (wr_x[w0 + 1] !== 10'd1 || wr_y[w0 + 1] !== 9'd0) begin nerr++; $display("FAIL f2_wr1_tag: got x%0d y%0d want x1 y0", wr_x[w0 + 1], wr_y[w0 + 1]); end
    nvec++; if (disp_cyc[d0 + 2] <= wr_cyc[w0 + 1]) begin nerr++; $display("FAIL f2_service_first: got dispatch cyc %0d want after write cyc %0d", disp_cyc[d0 + 2], wr_cyc[w0 + 1]); end
    bad = 0;
    for (int k = w0; k < wr_n && k < w0 + 8; k++) if ({wr_x[k], wr_y[k]} !== wr_exp[k]) bad++;
    nvec++; if (bad != 0 || wr_n - w0 != 8) begin nerr++; $display("FAIL f2_tags: got %0d bad of %0d writes want 0 of 8", bad, wr_n - w0); end
    nvec++; if (viol_n != v0) begin nerr++; $display("FAIL f2_onehot: got %0d violations want 0", viol_n - v0); end
  endtask

  task automatic test_all_busy();
    int d0, w0, f0;
    bit ok;
    resp_delay[0] = 20; resp_delay[1] = 20; rel_hold = 0;
    do_reset();
    d0 = disp_n; w0 = wr_n; f0 = fd_n;
    start_frame(RS, IS, RST, IST);
    wait_disp(d0 + 2, 50, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL f3_fill_timeout: got %0d dispatches want 2", disp_n - d0); end
    repeat (15) tick();
    nvec++; if (disp_n - d0 != 2) begin nerr++; $display("FAIL f3_stall: got %0d dispatches want 2", disp_n - d0); end
    wait_disp(d0 + 3, 200, ok);
    nvec++; if (!ok || disp_word[d0 + 2] !== exp_word(2, 0, RS, IS, RST, IST)) begin nerr++; $display("FAIL f3_next_pixel: got %h want %h", disp_word[d0 + 2], exp_word(2, 0, RS, IS, RST, IST)); end
    nvec++; if (wr_n <= w0 || disp_cyc[d0 + 2] <= wr_cyc[w0]) begin nerr++; $display("FAIL f3_after_release: got dispatch cyc %0d want after first write", disp_cyc[d0 + 2]); end
    wait_fd(f0, 2000, ok);
    nvec++; if (!ok || wr_n - w0 != 8) begin nerr++; $display("FAIL f3_writes: got %0d want 8", wr_n - w0); end
  endtask

  task automatic test_reset_in_ack();
    int w0, f0, k;
    bit ok;
    resp_delay[0] = 1; resp_delay[1] = 1; rel_hold = 0;
    do_reset();
    start_frame(RS, IS, RST, IST);
    ok = 1'b0;
    for (k = 0; k < 200; k++) begin
      if (ack != '0) begin ok = 1'b1; break; end
      tick();
    end
    nvec++; if (!ok) begin nerr++; $display("FAIL f4_ack_timeout: no ack within bound"); end
    eRST = 1'b1;
    tick();
    nvec++; if (ack !== '0 || busy !== 1'b0 || latch_en !== 1'b0 || fb_we !== 1'b0) begin nerr++; $display("FAIL f4_abort: ack=%b busy=%b latch=%b we=%b want all 0", ack, busy, latch_en, fb_we); end
    eRST = 1'b0;
    w0 = wr_n; f0 = fd_n;
    start_frame(32'h00100000, 32'hFFF00000, RST, IST);
    tick();
    nvec++; if (latch_en !== 1'b1 || word !== exp_word(0, 0, 32'h00100000, 32'hFFF00000, RST, IST)) begin nerr++; $display("FAIL f4_restart: latch=%b word %h want 1 %h", latch_en, word, exp_word(0, 0, 32'h00100000, 32'hFFF00000, RST, IST)); end
    wait_fd(f0, 1000, ok);
    nvec++; if (!ok || wr_n - w0 != 8) begin nerr++; $display("FAIL f4_writes: got %0d want 8", wr_n - w0); end
  endtask

  task automatic test_start_midframe();
    int d0, w0, f0, bad;
    bit ok;
    resp_delay[0] = 1; resp_delay[1] = 1; rel_hold = 0;
    do_reset();
    d0 = disp_n; w0 = wr_n; f0 = fd_n;
    start_frame(RS, IS, RST, IST);
    wait_disp(d0 + 3, 200, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL f5_progress: got %0d dispatches want 3", disp_n - d0); end
    start_frame(32'h12345678, 32'h0, 32'h1, 32'h1);
    wait_fd(f0, 1000, ok);
    nvec++; if (!ok || wr_n - w0 != HR * VR) begin nerr++; $display("FAIL f5_writes: got %0d want %0d", wr_n - w0, HR * VR); end
    bad = 0;
    for (int k = 0; k < 8; k++) if (disp_word[d0 + k] !== exp_word(k % HR, k / HR, RS, IS, RST, IST)) bad++;
    nvec++; if (bad != 0 || disp_n - d0 != 8) begin nerr++; $display("FAIL f5_words: got %0d bad of %0d want 0 of 8", bad, disp_n - d0); end
    repeat (4) tick();
    nvec++; if (fd_n - f0 != 1 || busy !== 1'b0) begin nerr++; $display("FAIL f5_single_frame: got %0d done busy=%b want 1 0", fd_n - f0, busy); end
  endtask

  task automatic test_release_hold();
    int d0, w0, f0, e0, mn;
    bit ok;
    resp_delay[0] = 1; resp_delay[1] = 1; rel_hold = 10;
    do_reset();
    d0 = disp_n; w0 = wr_n; f0 = fd_n; e0 = early_n;
    start_frame(RS, IS, RST, IST);
    wait_fd(f0, 2000, ok);
    nvec++; if (!ok || wr_n - w0 != 8) begin nerr++; $display("FAIL f6_writes: got %0d want 8", wr_n - w0); end
    nvec++; if (early_n != e0) begin nerr++; $display("FAIL f6_early_dispatch: got %0d want 0", early_n - e0); end
    mn = 1000;
    for (int k = d0; k < disp_n && k < d0 + 8; k++) if (disp_gap[k] < mn) mn = disp_gap[k];
    nvec++; if (mn < 12) begin nerr++; $display("FAIL f6_release_gap: got %0d cycles want >= 12", mn); end
    rel_hold = 0;
  endtask

  initial begin
    resp_delay[0] = 1; resp_delay[1] = 1;
    test_reset();
    test_frame();
    test_simultaneous();
    test_all_busy();
    test_reset_in_ack();
    test_start_midframe();
    test_release_hold();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mandel_dispatcher.md
# mandel_dispatcher

Frame-level scheduler for the bank of Mandelbrot iteration engines. It walks the screen in raster order and computes each pixel's complex coordinate (Re, Im) in Q8.24. It hands each pixel to an idle engine over the shared 83-bit word/address/latch bus, services engine `service_req` lines with a one-hot `ack`, and captures each returned iteration count from the shared `count_output` bus. Each captured count becomes one frame-buffer write.

## Interface
Parameters:
- `NUM_ENGINES`, 8: engines on the bus, 1..8; engine i answers to `engine_addr == i`.
- `H_RES`, 640: pixels per line, ≤ 1024.
- `V_RES`, 480: lines per frame, ≤ 512.
- `ACK_HOLD`, 3: cycles `ack[i]` stays high per service, ≥ 3.

Ports:
- `Engine_CLK`  in  1  single clock, all logic on posedge.
- `eRST`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a frame, ignored unless IDLE.
- `re_start`  in  32  signed Q8.24 Re of pixel (0,0), sampled on accepted `start`.
- `im_start`  in  32  signed Q8.24 Im of pixel (0,0), sampled on accepted `start`.
- `re_step`  in  32  signed Q8.24 Re increment per x, sampled on accepted `start`.
- `im_step`  in  32  signed Q8.24 Im increment per y, sampled on accepted `start`.
- `engine_addr`  out  3  target engine for the current dispatch.
- `word`  out  83  {x[82:73], y[72:64], Re[63:32], Im[31:0]}.
- `latch_en`  out  1  dispatch strobe.
- `service_req`  in  NUM_ENGINES  per-engine result-ready.
- `ack`  out  NUM_ENGINES  one-hot service grant.
- `count_output`  in  16  shared tri-state result bus from the acked engine.
- `fb_we`  out  1  frame-buffer write strobe.
- `fb_x`  out  10  pixel x for the write.
- `fb_y`  out  9  pixel y for the write.
- `fb_data`  out  16  iteration count for the write.
- `busy`  out  1  high from accepted `start` until `frame_done`.
- `frame_done`  out  1  one-cycle pulse when the last pixel is written.

## Operation
- Internal state per engine: an `eng_busy` bit and a 19-bit {x,y} tag, written at dispatch.
- States:
  - IDLE: no frame in progress; waits for `start`.
  - RUN: arbitrates between servicing results and dispatching new pixels.
  - DISPATCH: drives one pixel to one engine.
  - ACK: holds `ack` to the engine being serviced.
  - CAPTURE: writes the captured count to the frame buffer.
  - RELEASE: waits for the serviced engine to drop `service_req`.
  - DONE: signals end of frame.
- IDLE: on `start`, load the step/start registers, set x=y=0, Re=`re_start`, Im=`im_start`, clear all `eng_busy`, raise `busy`, then go to RUN.
- RUN priority: servicing results beats dispatching.
  1. If any `service_req[i] & eng_busy[i]` is set, grant one engine by round-robin, starting after the last serviced index, and go to ACK.
  2. Otherwise, if pixels remain and some `eng_busy[i]==0`, pick an engine by round-robin, starting after the last dispatched index, and go to DISPATCH.
  3. Otherwise, if all pixels are dispatched and no `eng_busy` bit is set, go to DONE.
  4. Otherwise, stay in RUN.
- `service_req` from a non-busy engine is ignored.
- DISPATCH, exactly 1 cycle:
  - Drive `latch_en=1`, `engine_addr=i`, and `word` for the current pixel.
  - Set `eng_busy[i]` and tag[i]={x,y}.
  - Advance the pixel: x+1 and Re+=re_step. At x=H_RES-1, wrap to x=0, Re=re_start, y+1, Im+=im_step.
  - Return to RUN.
- Arithmetic: 32-bit two's complement, wraps modulo 2^32, no saturation.
- ACK:
  - `ack[i]=1` for exactly ACK_HOLD cycles.
  - `count_output` is registered on the last ACK cycle.
- CAPTURE, 1 cycle:
  - `ack` is already low.
  - Drive `fb_we=1` with `fb_x`/`fb_y`=tag[i] and `fb_data`=captured count.
- RELEASE:
  - Wait until `service_req[i]==0` is sampled, then clear `eng_busy[i]` and return to RUN.
  - No timeout.
- DONE: pulse `frame_done` for 1 cycle, drop `busy`, go to IDLE.
- `start` outside IDLE has no effect.

## Timing
- Reset: all outputs 0 (`latch_en`, `ack`, `fb_we`, `busy`, `frame_done`, `engine_addr`, `word`, `fb_*`), all `eng_busy` bits cleared, state IDLE.
- Reset mid-frame aborts immediately. The frame is not resumed; a new `start` is required. Engines are reset by the same system reset.
- `start` to first `latch_en`: 2 cycles (IDLE→RUN→DISPATCH).
- Dispatch throughput: at most one pixel per 2 cycles (RUN, DISPATCH).
- `latch_en` is a single-cycle pulse. `word`/`engine_addr` are registered and stable for that whole cycle.
- Service cost: 1 (RUN) + ACK_HOLD + 1 (CAPTURE) + RELEASE cycles.
- `count_output` is sampled only on the final ACK cycle. The engine drives the bus by then, given ACK_HOLD ≥ 3.
- Only one `ack` bit is ever high. `ack` and `latch_en` are never high in the same cycle.
- Simultaneous `service_req` and idle engine: service wins, and the dispatch is retried on the next RUN visit.
- Last pixel: x=H_RES-1, y=V_RES-1. After it is dispatched, no further `latch_en` occurs this frame.

## Test plan
- Bench setup: behavioural engine models; the model returns count 3 when its address matches.
- Case 1:
  - Setup: H_RES=4, V_RES=2, NUM_ENGINES=2, re_start=0xFE000000, re_step=0x00800000, im_start=0x01000000, im_step=0xFF800000.
  - Required: 8 dispatches, with words for (x=3,y=0) carrying Re=0xFF800000 and (x=0,y=1) carrying Im=0x00800000.
  - Required: 8 `fb_we` writes, each with `fb_data`=3.
  - Required: one `frame_done` pulse, and `busy` low after it.
- Case 2: engine 0 and engine 1 raise `service_req` in the same cycle → they are acked in consecutive services with one-hot `ack`, each held exactly 3 cycles, and each `fb_x`/`fb_y` matches its dispatch tag.
- Case 3: all engines busy, none requesting → `latch_en` stays 0 and the pixel counter is unchanged until a RELEASE completes.
- Case 4: `eRST` asserted during ACK → next cycle `ack`=0, `busy`=0, state IDLE; a subsequent `start` re-dispatches pixel (0,0).
- Case 5: `start` pulsed mid-frame → ignored; the frame still produces exactly H_RES·V_RES writes.
- Case 6: engine model holds `service_req` high 10 cycles after `ack` drops → the dispatcher stays in RELEASE and does not re-dispatch to that engine early.
